// File: rtl/csi2_rx_pkg.sv
// Shared definitions for the CSI-2 RX decoder: default word width,
// line-buffer geometry and the pointer-wrap helper used by the line FIFO.
package csi2_rx_pkg;

   localparam int C_DWIDTH      = 64;
   localparam int C_LINE_DEPTH  = 1920;
   localparam int C_LINE_AWIDTH = 11;

   // Advance a buffer pointer, wrapping explicitly at depth-1 so that
   // non-power-of-two depths work without masking.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      if (ptr == depth - 1) begin
         return 0;
      end
      return ptr + 1;
   endfunction

endpackage

// File: rtl/cam_fifo_out_stage.sv
// Two-entry register queue (head + skid) forming the show-ahead output stage
// of the camera line FIFO. The caller guarantees never to push into a full
// queue and never to pop an empty one.
module cam_fifo_out_stage #(
   parameter int DWIDTH = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        count,
   output logic              valid,
   output logic [DWIDTH-1:0] data
);

   logic [DWIDTH-1:0] head;
   logic [DWIDTH-1:0] skid;

   // Queue update: head always holds the oldest word; the skid entry catches
   // a word arriving while the head is still waiting for the consumer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= 2'd0;
         head  <= '0;
         skid  <= '0;
      end else if (clear) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (count == 2'd2) begin
                  head <= skid;
                  skid <= push_data;
               end else begin
                  head <= push_data;
               end
            end
            2'b10: begin
               if (count == 2'd0) begin
                  head <= push_data;
               end else begin
                  skid <= push_data;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) begin
                  head <= skid;
               end
               count <= count - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign valid = (count != 2'd0);
   assign data  = head;

endmodule

// File: rtl/cam_line_fifo_ctrl.sv
// Single-clock FIFO controller for the CSI-2 RX camera line RAM. Owns the
// pointers and occupancy, hides the RAM's one-cycle read latency and presents
// a show-ahead valid/ready stream to the pixel unpacker.
module cam_line_fifo_ctrl
   import csi2_rx_pkg::*;
#(
   parameter int g_BUFF_AWIDTH = C_LINE_AWIDTH,
   parameter int g_DWIDTH      = C_DWIDTH,
   parameter int BUFF_DEPTH    = C_LINE_DEPTH
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   input  logic [g_DWIDTH-1:0]      in_data_i,
   output logic                     in_ready_o,
   output logic                     out_valid_o,
   output logic [g_DWIDTH-1:0]      out_data_o,
   input  logic                     out_ready_i,
   output logic [g_BUFF_AWIDTH:0]   fill_level_o,
   output logic                     ovf_o,
   output logic                     ram_we_o,
   output logic [g_BUFF_AWIDTH-1:0] ram_wr_addr_o,
   output logic [g_DWIDTH-1:0]      ram_wr_data_o,
   output logic [g_BUFF_AWIDTH-1:0] ram_rd_addr_o,
   input  logic [g_DWIDTH-1:0]      ram_rd_data_i
);

   localparam int CW = g_BUFF_AWIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUFF_DEPTH);

   logic [g_BUFF_AWIDTH-1:0] wptr;
   logic [g_BUFF_AWIDTH-1:0] rptr;
   logic [CW-1:0]            ram_cnt;
   logic                     inflight;
   logic [1:0]               out_cnt;
   logic                     accept;
   logic                     pop;
   logic                     issue;
   logic [2:0]               stage_load;

   // Handshakes and fetch decision. Ready depends only on registered count so
   // a read in the same cycle never frees a slot early.
   always_comb begin
      in_ready_o = (ram_cnt != DEPTH_C) & ~flush_i;
      accept     = in_valid_i & in_ready_o;
      pop        = out_valid_o & out_ready_i;
      stage_load = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
      issue      = (ram_cnt != '0) & (stage_load < 3'd2);
   end

   assign ram_we_o      = accept;
   assign ram_wr_addr_o = wptr;
   assign ram_wr_data_o = in_data_i;
   assign ram_rd_addr_o = rptr;
   assign fill_level_o  = ram_cnt + {{(CW-2){1'b0}}, out_cnt} + {{(CW-1){1'b0}}, inflight};

   // Pointer, occupancy, fetch-pipeline and overflow state; flush wins over
   // any write, fetch or pop in the same cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         ovf_o    <= 1'b0;
      end else if (flush_i) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         ovf_o    <= 1'b0;
      end else begin
         if (accept) begin
            wptr <= g_BUFF_AWIDTH'(next_ptr(32'(wptr), BUFF_DEPTH));
         end
         if (issue) begin
            rptr <= g_BUFF_AWIDTH'(next_ptr(32'(rptr), BUFF_DEPTH));
         end
         case ({accept, issue})
            2'b10:   ram_cnt <= ram_cnt + CW'(1);
            2'b01:   ram_cnt <= ram_cnt - CW'(1);
            default: ram_cnt <= ram_cnt;
         endcase
         inflight <= issue;
         if (in_valid_i && !in_ready_o) begin
            ovf_o <= 1'b1;
         end
      end
   end

   cam_fifo_out_stage #(
      .DWIDTH(g_DWIDTH)
   ) u_out_stage (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (flush_i),
      .push      (inflight),
      .push_data (ram_rd_data_i),
      .pop       (pop),
      .count     (out_cnt),
      .valid     (out_valid_o),
      .data      (out_data_o)
   );

endmodule
